// File: rtl/register_file.sv
// rtl/register_file.sv - 2R1W register file with zero entry, same-cycle bypass and a handshaked dump stream
module register_file #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 6,
    parameter int REGISTER_COUNT = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] read_address_1,
    output logic [DATA_WIDTH-1:0]    read_value_1,
    input  logic [ADDRESS_WIDTH-1:0] read_address_2,
    output logic [DATA_WIDTH-1:0]    read_value_2,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_value,
    input  logic                     write_enable,
    input  logic                     dump_start,
    input  logic                     dump_ready,
    output logic                     dump_valid,
    output logic [4:0]               dump_index,
    output logic [DATA_WIDTH-1:0]    dump_data,
    output logic                     dump_last,
    output logic                     dump_busy
);
    localparam int IDX_W = $clog2(REGISTER_COUNT);

    typedef enum logic {IDLE, STREAM} state_t;

    logic [DATA_WIDTH-1:0] entries_q [REGISTER_COUNT];
    logic [DATA_WIDTH-1:0] entries_d [REGISTER_COUNT];
    state_t                state_q, state_d;
    logic                  dump_valid_q, dump_valid_d;
    logic [4:0]            dump_index_q, dump_index_d;
    logic [DATA_WIDTH-1:0] dump_data_q, dump_data_d;
    logic                  dump_last_q, dump_last_d;
    logic [4:0]            next_index;
    logic                  write_ok;
    logic                  read_ok_1, read_ok_2;

    assign write_ok  = reset && write_enable && (write_address != '0)
                       && (int'(write_address) < REGISTER_COUNT);
    assign read_ok_1 = reset && (read_address_1 != '0) && (int'(read_address_1) < REGISTER_COUNT);
    assign read_ok_2 = reset && (read_address_2 != '0) && (int'(read_address_2) < REGISTER_COUNT);

    // A write in flight is forwarded so readers never see the stale entry.
    always_comb begin
        read_value_1 = '0;
        if (read_ok_1) begin
            if (write_ok && (write_address == read_address_1)) begin
                read_value_1 = write_value;
            end else begin
                read_value_1 = entries_q[read_address_1[IDX_W-1:0]];
            end
        end
    end

    always_comb begin
        read_value_2 = '0;
        if (read_ok_2) begin
            if (write_ok && (write_address == read_address_2)) begin
                read_value_2 = write_value;
            end else begin
                read_value_2 = entries_q[read_address_2[IDX_W-1:0]];
            end
        end
    end

    always_comb begin
        entries_d = entries_q;
        if (write_ok) begin
            entries_d[write_address[IDX_W-1:0]] = write_value;
        end
    end

    // Beats load from entries_d so a write landing on the same edge is captured.
    always_comb begin
        state_d      = state_q;
        dump_valid_d = dump_valid_q;
        dump_index_d = dump_index_q;
        dump_data_d  = dump_data_q;
        dump_last_d  = dump_last_q;
        next_index   = dump_index_q + 5'd1;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d      = STREAM;
                    dump_valid_d = 1'b1;
                    dump_index_d = '0;
                    dump_data_d  = entries_d[0];
                    dump_last_d  = (REGISTER_COUNT == 1);
                end
            end
            STREAM: begin
                if (dump_ready) begin
                    if (dump_last_q) begin
                        state_d      = IDLE;
                        dump_valid_d = 1'b0;
                        dump_index_d = '0;
                        dump_data_d  = '0;
                        dump_last_d  = 1'b0;
                    end else begin
                        dump_index_d = next_index;
                        dump_data_d  = entries_d[next_index[IDX_W-1:0]];
                        dump_last_d  = (int'(next_index) == REGISTER_COUNT - 1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REGISTER_COUNT; i++) begin
                entries_q[i] <= '0;
            end
            state_q      <= IDLE;
            dump_valid_q <= 1'b0;
            dump_index_q <= '0;
            dump_data_q  <= '0;
            dump_last_q  <= 1'b0;
        end else begin
            entries_q    <= entries_d;
            state_q      <= state_d;
            dump_valid_q <= dump_valid_d;
            dump_index_q <= dump_index_d;
            dump_data_q  <= dump_data_d;
            dump_last_q  <= dump_last_d;
        end
    end

    assign dump_valid = dump_valid_q;
    assign dump_index = dump_index_q;
    assign dump_data  = dump_data_q;
    assign dump_last  = dump_last_q;
    assign dump_busy  = (state_q == STREAM);
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;
    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  read_address_1, read_address_2, write_address;
    logic [31:0] read_value_1, read_value_2, write_value, dump_data;
    logic        write_enable, dump_start, dump_ready;
    logic        dump_valid, dump_last, dump_busy;
    logic [4:0]  dump_index;
    int checks = 0;
    int failures = 0;

    register_file dut (
        .clock(clock), .reset(reset),
        .read_address_1(read_address_1), .read_value_1(read_value_1),
        .read_address_2(read_address_2), .read_value_2(read_value_2),
        .write_address(write_address), .write_value(write_value), .write_enable(write_enable),
        .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dump_valid),
        .dump_index(dump_index), .dump_data(dump_data), .dump_last(dump_last), .dump_busy(dump_busy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; write_enable = 0; write_address = 0; write_value = 0;
        read_address_1 = 5; read_address_2 = 31; dump_start = 0; dump_ready = 0;
        step();
        checks++;
        if (read_value_1 !== 32'h0 || read_value_2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_reads got %h %h expected 0 0", read_value_1, read_value_2);
        end
        checks++;
        if ({dump_valid, dump_index, dump_data, dump_last, dump_busy} !== '0) begin
            failures++;
            $display("FAIL reset_dump got v=%b i=%0d d=%h l=%b b=%b expected all 0",
                     dump_valid, dump_index, dump_data, dump_last, dump_busy);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        read_address_1 = 5; read_address_2 = 5;
        #1;
        checks++;
        if (read_value_1 !== 32'h0) begin
            failures++;
            $display("FAIL read5_before got %h expected 0", read_value_1);
        end
        write_enable = 1; write_address = 5; write_value = 32'hDEADBEEF;
        step();
        write_enable = 0;
        #1;
        checks++;
        if (read_value_1 !== 32'hDEADBEEF || read_value_2 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL read5_after got %h %h expected deadbeef", read_value_1, read_value_2);
        end
    endtask

    task automatic test_invalid_addresses();
        write_enable = 1; write_address = 0; write_value = 32'h1234;
        step();
        write_address = 40; write_value = 32'h5678;
        step();
        write_enable = 0;
        read_address_1 = 0; read_address_2 = 40;
        #1;
        checks++;
        if (read_value_1 !== 32'h0 || read_value_2 !== 32'h0) begin
            failures++;
            $display("FAIL invalid_addr got %h %h expected 0 0", read_value_1, read_value_2);
        end
    endtask

    task automatic test_bypass();
        write_enable = 1; write_address = 7; write_value = 32'hA5A5A5A5;
        read_address_1 = 7; read_address_2 = 7;
        #1;
        checks++;
        if (read_value_1 !== 32'hA5A5A5A5 || read_value_2 !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL bypass got %h %h expected a5a5a5a5", read_value_1, read_value_2);
        end
        step();
        write_enable = 0;
    endtask

    task automatic test_full_dump();
        for (int i = 1; i < 32; i++) begin
            write_enable = 1; write_address = 6'(i); write_value = i * 32'h11;
            step();
        end
        write_enable = 0;
        dump_ready = 1; dump_start = 1;
        step();
        dump_start = 0;
        for (int b = 0; b < 32; b++) begin
            checks++;
            if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_index !== 5'(b)
                || dump_data !== b * 32'h11 || dump_last !== (b == 31)) begin
                failures++;
                $display("FAIL dump_beat%0d got v=%b b=%b i=%0d d=%h l=%b expected 1 1 %0d %h %b",
                         b, dump_valid, dump_busy, dump_index, dump_data, dump_last,
                         b, b * 32'h11, b == 31);
            end
            step();
        end
        checks++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_last !== 1'b0) begin
            failures++;
            $display("FAIL dump_done got b=%b v=%b l=%b expected 0 0 0", dump_busy, dump_valid, dump_last);
        end
    endtask

    task automatic test_stall();
        int guard;
        dump_ready = 1; dump_start = 1;
        step();
        dump_start = 0;
        repeat (4) step();
        dump_ready = 0;
        write_enable = 1; write_address = 4; write_value = 32'hFFFF;
        for (int c = 0; c < 3; c++) begin
            dump_start = (c == 1);
            step();
            write_enable = 0;
            dump_start = 0;
            checks++;
            if (dump_valid !== 1'b1 || dump_index !== 5'd4 || dump_data !== 32'h44 || dump_last !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d got v=%b i=%0d d=%h l=%b expected 1 4 44 0",
                         c, dump_valid, dump_index, dump_data, dump_last);
            end
        end
        read_address_1 = 4;
        #1;
        checks++;
        if (read_value_1 !== 32'hFFFF) begin
            failures++;
            $display("FAIL stall_write got %h expected ffff", read_value_1);
        end
        dump_ready = 1;
        step();
        checks++;
        if (dump_index !== 5'd5 || dump_data !== 32'h55) begin
            failures++;
            $display("FAIL stall_next got i=%0d d=%h expected 5 55", dump_index, dump_data);
        end
        guard = 0;
        while (dump_busy && guard < 40) begin
            step();
            guard++;
        end
        checks++;
        if (dump_busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_finish got busy=%b expected 0", dump_busy);
        end
    endtask

    task automatic test_reset_mid_dump();
        dump_ready = 1; dump_start = 1;
        step();
        dump_start = 0;
        repeat (10) step();
        checks++;
        if (dump_index !== 5'd10 || dump_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_reach got i=%0d b=%b expected 10 1", dump_index, dump_busy);
        end
        reset = 0;
        #1;
        checks++;
        if ({dump_valid, dump_busy, dump_index, dump_data, dump_last} !== '0) begin
            failures++;
            $display("FAIL mid_reset got v=%b b=%b i=%0d d=%h l=%b expected all 0",
                     dump_valid, dump_busy, dump_index, dump_data, dump_last);
        end
        #1;
        reset = 1;
        read_address_1 = 5; read_address_2 = 31;
        step();
        checks++;
        if (read_value_1 !== 32'h0 || read_value_2 !== 32'h0 || dump_busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_release got %h %h b=%b expected 0 0 0", read_value_1, read_value_2, dump_busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_invalid_addresses();
        test_bypass();
        test_full_dump();
        test_stall();
        test_reset_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
